// File: rtl/decoder.sv
// RV32I integer-ALU decoder for OP and OP-IMM instructions.
// All decode outputs are combinational functions of the instruction word.
// The only state is a sticky flag that records any illegal encoding seen since reset.
module decoder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] immediate,
  output logic        alu_source,
  output logic [3:0]  alu_op,
  output logic        should_write,
  output logic        illegal,
  output logic        illegal_seen
);

  // ALU operation encoding shared with the ALU.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_legal;
  logic       w_is_r;
  logic       w_is_shift;
  alu_op_e    w_op;
  logic       r_illegal_seen;

  assign w_opcode = instruction[6:0];
  assign w_funct3 = instruction[14:12];
  assign w_funct7 = instruction[31:25];

  // Register indices are passed through raw, legal or not.
  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];
  assign rd  = instruction[11:7];

  // Classify the instruction and pick the ALU operation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    w_legal    = 1'b0;
    w_is_r     = 1'b0;
    w_is_shift = 1'b0;
    w_op       = ALU_ADD;
    case (w_opcode)
      OPC_OP: begin
        w_is_r = 1'b1;
        case ({w_funct7, w_funct3})
          {F7_BASE, 3'b000}: begin w_legal = 1'b1; w_op = ALU_ADD;  end
          {F7_ALT,  3'b000}: begin w_legal = 1'b1; w_op = ALU_SUB;  end
          {F7_BASE, 3'b001}: begin w_legal = 1'b1; w_op = ALU_SLL;  end
          {F7_BASE, 3'b010}: begin w_legal = 1'b1; w_op = ALU_SLT;  end
          {F7_BASE, 3'b011}: begin w_legal = 1'b1; w_op = ALU_SLTU; end
          {F7_BASE, 3'b100}: begin w_legal = 1'b1; w_op = ALU_XOR;  end
          {F7_BASE, 3'b101}: begin w_legal = 1'b1; w_op = ALU_SRL;  end
          {F7_ALT,  3'b101}: begin w_legal = 1'b1; w_op = ALU_SRA;  end
          {F7_BASE, 3'b110}: begin w_legal = 1'b1; w_op = ALU_OR;   end
          {F7_BASE, 3'b111}: begin w_legal = 1'b1; w_op = ALU_AND;  end
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        case (w_funct3)
          3'b000: begin w_legal = 1'b1; w_op = ALU_ADD;  end
          3'b010: begin w_legal = 1'b1; w_op = ALU_SLT;  end
          3'b011: begin w_legal = 1'b1; w_op = ALU_SLTU; end
          3'b100: begin w_legal = 1'b1; w_op = ALU_XOR;  end
          3'b110: begin w_legal = 1'b1; w_op = ALU_OR;   end
          3'b111: begin w_legal = 1'b1; w_op = ALU_AND;  end
          3'b001: begin
            w_is_shift = 1'b1;
            if (w_funct7 == F7_BASE) begin w_legal = 1'b1; w_op = ALU_SLL; end
          end
          3'b101: begin
            w_is_shift = 1'b1;
            if (w_funct7 == F7_BASE) begin
              w_legal = 1'b1; w_op = ALU_SRL;
            end else if (w_funct7 == F7_ALT) begin
              w_legal = 1'b1; w_op = ALU_SRA;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Drive decode outputs; illegal words collapse to a harmless ADD with no write.
  always_comb begin
    illegal      = ~w_legal;
    should_write = w_legal;
    alu_source   = w_legal & w_is_r;
    alu_op       = w_legal ? w_op : ALU_ADD;
    immediate    = 32'h0000_0000;
    if (w_legal && !w_is_r) begin
      if (w_is_shift) immediate = {27'b0, instruction[24:20]};
      else            immediate = {{20{instruction[31]}}, instruction[31:20]};
    end
  end

  // Sticky illegal flag: set on any clocked illegal word, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!reset_n)     r_illegal_seen <= 1'b0;
    else if (illegal) r_illegal_seen <= 1'b1;
  end

  assign illegal_seen = r_illegal_seen;

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for the RV32I OP/OP-IMM decoder.
module tb_decoder;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [31:0] LEGAL_WORD = 32'h00730293;  // addi x5,x6,7

  logic        clock;
  logic        reset_n;
  logic [31:0] instruction;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] immediate;
  logic        alu_source;
  logic [3:0]  alu_op;
  logic        should_write;
  logic        illegal;
  logic        illegal_seen;

  int total = 0;
  int bad   = 0;

  decoder dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .instruction  (instruction),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .immediate    (immediate),
    .alu_source   (alu_source),
    .alu_op       (alu_op),
    .should_write (should_write),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  // Apply a word between edges and compare every decode output.
  task automatic decode_check(input string name, input logic [31:0] word,
                              input logic [4:0] e_rd, input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                              input logic [31:0] e_imm, input logic e_src, input logic [3:0] e_op,
                              input logic e_wr, input logic e_ill);
    @(negedge clock);
    instruction = word;
    #1;
    check({name, ".rd"},     {27'b0, rd},           {27'b0, e_rd});
    check({name, ".rs1"},    {27'b0, rs1},          {27'b0, e_rs1});
    check({name, ".rs2"},    {27'b0, rs2},          {27'b0, e_rs2});
    check({name, ".imm"},    immediate,             e_imm);
    check({name, ".src"},    {31'b0, alu_source},   {31'b0, e_src});
    check({name, ".op"},     {28'b0, alu_op},       {28'b0, e_op});
    check({name, ".wr"},     {31'b0, should_write}, {31'b0, e_wr});
    check({name, ".ill"},    {31'b0, illegal},      {31'b0, e_ill});
  endtask

  initial begin
    reset_n     = 1'b0;
    instruction = LEGAL_WORD;
    #12;
    check("seen_in_reset", {31'b0, illegal_seen}, 32'd0);
    reset_n = 1'b1;

    // Legal word over several clocks keeps the flag clear.
    repeat (4) @(posedge clock);
    #1;
    check("seen_after_legal", {31'b0, illegal_seen}, 32'd0);

    // Legal decode vectors.
    decode_check("sub",   32'h40c58533, 5'd10, 5'd11, 5'd12, 32'h0000_0000, 1'b1, OP_SUB,  1'b1, 1'b0);
    decode_check("addi",  32'h00730293, 5'd5,  5'd6,  5'd7,  32'h0000_0007, 1'b0, OP_ADD,  1'b1, 1'b0);
    decode_check("slti",  32'hf9caaa13, 5'd20, 5'd21, 5'd28, 32'hffff_ff9c, 1'b0, OP_SLT,  1'b1, 1'b0);
    decode_check("sltiu", 32'h0007b793, 5'd15, 5'd15, 5'd0,  32'h0000_0000, 1'b0, OP_SLTU, 1'b1, 1'b0);
    decode_check("xori",  32'h00a04013, 5'd0,  5'd0,  5'd10, 32'h0000_000a, 1'b0, OP_XOR,  1'b1, 1'b0);
    decode_check("ori",   32'hc00fef93, 5'd31, 5'd31, 5'd0,  32'hffff_fc00, 1'b0, OP_OR,   1'b1, 1'b0);
    decode_check("andi",  32'h7ffa7993, 5'd19, 5'd20, 5'd31, 32'h0000_07ff, 1'b0, OP_AND,  1'b1, 1'b0);
    decode_check("slli",  32'h01e11093, 5'd1,  5'd2,  5'd30, 32'h0000_001e, 1'b0, OP_SLL,  1'b1, 1'b0);
    decode_check("srli",  32'h00125193, 5'd3,  5'd4,  5'd1,  32'h0000_0001, 1'b0, OP_SRL,  1'b1, 1'b0);
    decode_check("srai",  32'h40035293, 5'd5,  5'd6,  5'd0,  32'h0000_0000, 1'b0, OP_SRA,  1'b1, 1'b0);
    decode_check("and",   32'h00c5f533, 5'd10, 5'd11, 5'd12, 32'h0000_0000, 1'b1, OP_AND,  1'b1, 1'b0);
    decode_check("sra",   32'h40c5d533, 5'd10, 5'd11, 5'd12, 32'h0000_0000, 1'b1, OP_SRA,  1'b1, 1'b0);
    #1;
    check("seen_after_legal_set", {31'b0, illegal_seen}, 32'd0);

    // Illegal load word: decode collapses, flag still clear before the edge.
    decode_check("load", 32'h00000003, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b0, OP_ADD, 1'b0, 1'b1);
    check("seen_before_edge", {31'b0, illegal_seen}, 32'd0);
    @(posedge clock);
    #1;
    check("seen_at_edge", {31'b0, illegal_seen}, 32'd1);

    // Back to legal: the flag stays set.
    @(negedge clock);
    instruction = LEGAL_WORD;
    repeat (3) @(posedge clock);
    #1;
    check("seen_sticky", {31'b0, illegal_seen}, 32'd1);

    // Bad funct7 on an R-type and an OP-IMM shift.
    decode_check("mul",   32'h02c58533, 5'd10, 5'd11, 5'd12, 32'h0000_0000, 1'b0, OP_ADD, 1'b0, 1'b1);
    decode_check("slli7", 32'h40111093, 5'd1,  5'd2,  5'd1,  32'h0000_0000, 1'b0, OP_ADD, 1'b0, 1'b1);

    // Asynchronous reset between edges clears the flag at once.
    @(negedge clock);
    instruction = LEGAL_WORD;
    #2;
    reset_n = 1'b0;
    #1;
    check("seen_async_clear", {31'b0, illegal_seen}, 32'd0);

    // Reset wins over an illegal word across clock edges, and X input cannot latch it.
    instruction = 32'h00000003;
    repeat (2) @(posedge clock);
    #1;
    check("seen_reset_wins", {31'b0, illegal_seen}, 32'd0);
    instruction = 32'hxxxx_xxxx;
    repeat (2) @(posedge clock);
    #1;
    check("seen_x_in_reset", {31'b0, illegal_seen}, 32'd0);

    // Leave reset with a legal word: flag remains clear.
    @(negedge clock);
    instruction = LEGAL_WORD;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("seen_after_release", {31'b0, illegal_seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder.md
# decoder

Combinational RV32I instruction decoder for the integer ALU path (OP and OP-IMM opcodes), sitting between instruction fetch and the register file/ALU. It extracts register indices, forms the immediate, selects the ALU operation and operand source, and flags the register write. A single clocked element, a sticky illegal-instruction flag, is the only state in the block.

## Interface
- No parameters.
- clock  input  1  system clock; only the sticky flag uses it.
- reset_n  input  1  asynchronous, active-low reset; clears the sticky flag.
- instruction  input  32  raw RV32I instruction word.
- rs1  output  5  instruction[19:15], always driven raw.
- rs2  output  5  instruction[24:20], always driven raw.
- rd  output  5  instruction[11:7], always driven raw.
- immediate  output  32  decoded immediate; see Operation.
- alu_source  output  1  1 = second ALU operand from rs2 (R-type); 0 = from immediate.
- alu_op  output  4  ALU operation code, per the shared ALU op definitions: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- should_write  output  1  1 = write the result to rd.
- illegal  output  1  combinational: the current instruction is not a supported OP/OP-IMM encoding.
- illegal_seen  output  1  registered sticky copy of illegal.

## Operation
- The opcode is instruction[6:0], funct3 is [14:12], and funct7 is [31:25].
- OP (0110011), R-type:
  - Sets alu_source=1, immediate=0 and should_write=1.
  - funct3/funct7 map as follows:
    - 000/0000000 ADD; 000/0100000 SUB.
    - 001/0000000 SLL.
    - 010/0000000 SLT; 011/0000000 SLTU.
    - 100/0000000 XOR.
    - 101/0000000 SRL; 101/0100000 SRA.
    - 110/0000000 OR; 111/0000000 AND.
- OP-IMM (0010011), I-type:
  - Sets alu_source=0 and should_write=1.
  - funct3 maps 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - For these, immediate = sign-extended instruction[31:20].
- OP-IMM shifts:
  - funct3 001 with funct7 0000000 is SLL; funct3 101 with funct7 0000000 is SRL; funct3 101 with funct7 0100000 is SRA.
  - For shifts, immediate = zero-extended shamt, instruction[24:20]. funct7 bits never appear in immediate.
- should_write is 1 for every legal instruction, including rd = x0. Writes to x0 are suppressed in the register file, not here.
- An instruction is illegal if it has any other opcode, or any funct3/funct7 combination not listed above. For an illegal instruction:
  - illegal=1, should_write=0, alu_op=ADD, alu_source=0, immediate=0.
  - rs1, rs2 and rd remain the raw fields.
- Decode outputs depend only on instruction. reset_n does not affect them.

## Timing
- rs1, rs2, rd, immediate, alu_source, alu_op, should_write and illegal are purely combinational. They are valid within the same cycle, with zero latency and no handshake.
- illegal_seen:
  - Reset value is 0; it is cleared asynchronously whenever reset_n=0.
  - It is set to 1 on a rising clock edge while illegal=1 and reset_n=1.
  - It stays 1 until the next reset.
  - If reset is asserted on the same edge where illegal=1, reset wins.
- Inputs containing X or Z must not latch illegal_seen while reset_n=0.

## Test plan
- R-type SUB:
  - Stimulus: sub x10,x11,x12, 32'h40c58533.
  - Required: rs1=11, rs2=12, rd=10, alu_source=1, alu_op=SUB, should_write=1, illegal=0.
- OP-IMM arithmetic and compare, each checking the listed rd, rs1 and immediate with alu_source=0 and should_write=1:
  - addi: 32'h00730293 -> rd=5, rs1=6, imm=7, alu_op=ADD.
  - slti: 32'hf9caaa13 -> rd=20, rs1=21, imm=-100 (32'hffffff9c), alu_op=SLT.
  - sltiu: 32'h0007b793 -> rd=15, rs1=15, imm=0, alu_op=SLTU.
- OP-IMM logical:
  - xori: 32'h00a04013 -> rd=0, rs1=0, imm=10, alu_op=XOR, should_write=1.
  - ori: 32'hc00fef93 -> rd=31, rs1=31, imm=-1024, alu_op=OR.
  - andi: 32'h7ffa7993 -> rd=19, rs1=20, imm=2047, alu_op=AND.
- OP-IMM shifts:
  - slli: 32'h01e11093 -> rd=1, rs1=2, imm=30, alu_op=SLL.
  - srli: 32'h00125193 -> rd=3, rs1=4, imm=1, alu_op=SRL.
  - srai: 32'h40035293 -> rd=5, rs1=6, imm=0, alu_op=SRA.
- Illegal decode:
  - Stimulus: 32'h00000003 (load), and separately 32'h02c58533 (funct7 0000001).
  - Required: illegal=1, should_write=0, alu_op=ADD, immediate=0.
- Sticky flag:
  - Stimulus sequence:
    - Pulse reset_n low, then release.
    - Apply a legal word for several clocks.
    - Apply an illegal word for one clock edge.
    - Return to a legal word.
    - Assert reset_n low between clock edges.
  - Required: illegal_seen=0 after reset, 1 from the illegal edge onward, and 0 immediately on the asynchronous reset.
